seven_seg_digit_driver: RTL and testbench

SEVEN_SEG_DIGIT_DRIVER -- requirements
Module: seven_seg_digit_driver

---
 rtl/seven_seg_digit_driver.sv | 174 +++++++++++++++++
 tb/tb_seven_seg_digit_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_digit_driver.sv
// Seven-segment digit driver for a four-digit multiplexed display.
// The scanner's anode select is synchronized before use. Loaded values wait in a
// pending register until a frame boundary, so a frame is never torn. Outputs stay
// dark for a few cycles after every digit change to suppress ghosting.
module seven_seg_digit_driver #(
    parameter int BLANK_CYCLES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  anode_in,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [3:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        load_ack,
    output logic        pending
);

    // The change edge is itself the first dark cycle, so the counter reloads with one less.
    localparam logic [3:0] BLANK_LOAD = (BLANK_CYCLES == 0) ? 4'd0 : 4'(BLANK_CYCLES - 1);
    localparam logic [3:0] ANODE_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF    = 7'b1111111;

    logic [3:0]  anode_meta;
    logic [3:0]  anode_s;
    logic [3:0]  anode_prev;
    logic [15:0] pend_value;
    logic [3:0]  pend_dp;
    logic [15:0] disp_value;
    logic [3:0]  disp_dp;
    logic [3:0]  blank_cnt;

    logic        valid;
    logic [1:0]  idx;
    logic        change;
    logic        boundary;
    logic        commit;
    logic [15:0] disp_now;
    logic [3:0]  disp_dp_now;
    logic [3:0]  nibble;
    logic [6:0]  hex_seg;
    logic [3:0]  lead_zero;
    logic        blanked;
    logic [3:0]  blank_cnt_next;

    // Decode the synchronized one-hot select into a digit index.
    always_comb begin
        valid = 1'b1;
        idx   = 2'd0;
        case (anode_s)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: valid = 1'b0;
        endcase
    end

    assign change   = (anode_s != anode_prev);
    assign boundary = (anode_s == 4'b1110) && (anode_prev != 4'b1110);
    assign commit   = boundary && pending;

    // Outputs use the contents being committed on this edge, so digit 0 of a
    // new frame already shows the new value even with no blanking.
    assign disp_now    = commit ? pend_value : disp_value;
    assign disp_dp_now = commit ? pend_dp    : disp_dp;
    assign nibble      = disp_now[{idx, 2'b00} +: 4];

    // Digit i is a leading zero when it and every more significant nibble are zero.
    assign lead_zero[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lead_zero
            assign lead_zero[gi] = ~|disp_now[15:4*gi];
        end
    endgenerate

    // Hex to active-low {g,f,e,d,c,b,a}.
    always_comb begin
        hex_seg = SEG_OFF;
        case (nibble)
            4'h0: hex_seg = 7'b1000000;
            4'h1: hex_seg = 7'b1111001;
            4'h2: hex_seg = 7'b0100100;
            4'h3: hex_seg = 7'b0110000;
            4'h4: hex_seg = 7'b0011001;
            4'h5: hex_seg = 7'b0010010;
            4'h6: hex_seg = 7'b0000010;
            4'h7: hex_seg = 7'b1111000;
            4'h8: hex_seg = 7'b0000000;
            4'h9: hex_seg = 7'b0010000;
            4'hA: hex_seg = 7'b0001000;
            4'hB: hex_seg = 7'b0000011;
            4'hC: hex_seg = 7'b1000110;
            4'hD: hex_seg = 7'b0100001;
            4'hE: hex_seg = 7'b0000110;
            4'hF: hex_seg = 7'b0001110;
            default: hex_seg = SEG_OFF;
        endcase
    end

    // Anti-ghosting counter: a change restarts it, otherwise it counts down to zero.
    always_comb begin
        blank_cnt_next = blank_cnt;
        blanked        = 1'b0;
        if (change) begin
            blank_cnt_next = BLANK_LOAD;
            blanked        = (BLANK_CYCLES != 0);
        end else if (blank_cnt != 4'd0) begin
            blank_cnt_next = blank_cnt - 4'd1;
            blanked        = 1'b1;
        end
    end

    // Two-flop synchronizer plus one history stage for change/boundary detection.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode_meta <= ANODE_OFF;
            anode_s    <= ANODE_OFF;
            anode_prev <= ANODE_OFF;
            blank_cnt  <= 4'd0;
        end else begin
            anode_meta <= anode_in;
            anode_s    <= anode_meta;
            anode_prev <= anode_s;
            blank_cnt  <= blank_cnt_next;
        end
    end

    // Pending/display registers: load always wins the pending slot, commit only at a boundary.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_value <= 16'h0000;
            pend_dp    <= 4'h0;
            pending    <= 1'b0;
            disp_value <= 16'h0000;
            disp_dp    <= 4'h0;
            load_ack   <= 1'b0;
        end else begin
            load_ack <= load;
            if (commit) begin
                disp_value <= pend_value;
                disp_dp    <= pend_dp;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp_in;
                pending    <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // Registered pin drivers: dark while blanking or on an invalid select.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            anode <= ANODE_OFF;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else if (!valid || blanked) begin
            anode <= ANODE_OFF;
            seg   <= SEG_OFF;
            dp    <= 1'b1;
        end else begin
            anode <= anode_s;
            seg   <= (blank_lz && lead_zero[idx]) ? SEG_OFF : hex_seg;
            dp    <= ~disp_dp_now[idx];
        end
    end

endmodule

// File: tb/tb_seven_seg_digit_driver.sv
// Directed plus randomized bench for seven_seg_digit_driver with a behavioural
// model: anode_s is the input sampled two edges earlier, a digit is lit once
// BLANK edges have passed since the last select change, and leading zeros are
// found by shifting the displayed value.
module tb_seven_seg_digit_driver;

    localparam int BLANK = 4;
    localparam logic [13:0] RST_OUT = {4'b1111, 7'b1111111, 1'b1, 1'b0, 1'b0};
    localparam logic [6:0] HEX [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    localparam logic [3:0] ROT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  anode_in;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        load_ack;
    logic        pending;
    logic [13:0] outs;

    int n_cmp = 0;
    int n_err = 0;

    // Model state
    logic [3:0]  samp [$];
    int          n;
    int          last_chg;
    logic [15:0] m_disp, m_pval;
    logic [3:0]  m_ddp, m_pdp;
    logic        m_pend, m_ack;
    logic [13:0] exp_out;

    seven_seg_digit_driver #(.BLANK_CYCLES(BLANK)) dut (
        .clock(clock), .reset(reset), .anode_in(anode_in), .value(value),
        .dp_in(dp_in), .load(load), .blank_lz(blank_lz), .anode(anode),
        .seg(seg), .dp(dp), .load_ack(load_ack), .pending(pending));

    assign outs = {anode, seg, dp, load_ack, pending};

    always #5 clock = ~clock;

    // anode_s as seen just before edge k (k counted from 1 after reset release)
    function automatic logic [3:0] sv_at(input int k);
        if (k >= 3) return samp[k-3];
        return 4'b1111;
    endfunction

    task automatic model_reset();
        samp.delete();
        n = 0; last_chg = -100;
        m_disp = '0; m_pval = '0; m_ddp = '0; m_pdp = '0;
        m_pend = 1'b0; m_ack = 1'b0;
        exp_out = RST_OUT;
    endtask

    task automatic model_edge();
        logic [3:0] cur, prv;
        logic bnd;
        int idx;
        logic [6:0] s;
        n++;
        cur = sv_at(n);
        prv = sv_at(n - 1);
        if (cur != prv) last_chg = n;
        bnd = (cur == 4'b1110) && (prv != 4'b1110);
        if (bnd && m_pend) begin
            m_disp = m_pval;
            m_ddp  = m_pdp;
        end
        if (load) begin
            m_pval = value; m_pdp = dp_in; m_pend = 1'b1;
        end else if (bnd) begin
            m_pend = 1'b0;
        end
        m_ack = load;
        samp.push_back(anode_in);
        idx = -1;
        for (int i = 0; i < 4; i++) if (cur == ROT[i]) idx = i;
        if (idx < 0 || (n - last_chg) < BLANK) begin
            exp_out = {4'b1111, 7'b1111111, 1'b1, m_ack, m_pend};
        end else begin
            s = HEX[m_disp[4*idx +: 4]];
            if (blank_lz && idx > 0 && (m_disp >> (4*idx)) == 16'h0) s = 7'b1111111;
            exp_out = {cur, s, ~m_ddp[idx], m_ack, m_pend};
        end
    endtask

    task automatic check(input string tag, input logic [13:0] obs, input logic [13:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%b expected=%b (edge %0d)", tag, obs, expv, n);
        end
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        if (reset) model_edge();
        else exp_out = RST_OUT;
        @(negedge clock);
        check(tag, outs, exp_out);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input string tag);
        value = v; dp_in = d; load = 1'b1;
        $display("load value=%h dp=%b anode_in=%b", v, d, anode_in);
        tick(tag);
        load = 1'b0;
    endtask

    initial begin
        reset = 1'b0; anode_in = 4'b1111; value = '0; dp_in = '0;
        load = 1'b0; blank_lz = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        check("reset_state", outs, RST_OUT);
        reset = 1'b1;

        // Steady digit 0 after reset: sync latency, blank, then zero shown.
        anode_in = 4'b1110;
        repeat (10) tick("startup");

        // Mid-frame load, then rotate every 50 cycles.
        do_load(16'h12AF, 4'b0100, "load_12af");
        repeat (5) tick("pending_hold");
        for (int r = 1; r <= 8; r++) begin
            anode_in = ROT[r % 4];
            repeat (50) tick("rotate50");
        end

        // Changes arriving mid-blank restart the count.
        anode_in = 4'b1101; repeat (2) tick("restart");
        anode_in = 4'b1011; repeat (2) tick("restart");
        anode_in = 4'b0111; repeat (10) tick("restart");

        // Leading-zero blanking, live toggle.
        blank_lz = 1'b1;
        do_load(16'h0030, 4'b0000, "load_0030");
        for (int r = 0; r < 8; r++) begin
            anode_in = ROT[r % 4];
            repeat (12) tick("lz_on");
        end
        blank_lz = 1'b0;
        for (int r = 0; r < 4; r++) begin
            anode_in = ROT[r % 4];
            repeat (12) tick("lz_off");
        end

        // Load coinciding with a frame boundary.
        anode_in = 4'b1101; repeat (10) tick("coinc_setup");
        do_load(16'h1111, 4'b0001, "load_1111");
        repeat (3) tick("coinc_setup");
        anode_in = 4'b1110;
        tick("coinc_sync");
        tick("coinc_sync");
        do_load(16'h2222, 4'b0010, "load_2222_boundary");
        check("coinc_pending", {13'b0, pending}, 14'd1);
        repeat (8) tick("coinc_show_1111");
        for (int r = 1; r <= 4; r++) begin
            anode_in = ROT[r % 4];
            repeat (10) tick("coinc_next_frame");
        end

        // Randomized traffic.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 29) == 0) begin
                value = 16'($urandom); dp_in = 4'($urandom); load = 1'b1;
                $display("load value=%h dp=%b anode_in=%b", value, dp_in, anode_in);
            end
            if ($urandom_range(0, 19) == 0)
                anode_in = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ROT[$urandom_range(0, 3)];
            if ($urandom_range(0, 99) == 0) blank_lz = ~blank_lz;
            tick("random");
            load = 1'b0;
        end

        // Invalid selects keep everything dark.
        anode_in = 4'b1001; repeat (10) tick("invalid_1001");
        check("invalid_off", outs, RST_OUT);
        anode_in = 4'b1111; repeat (10) tick("invalid_1111");

        // Reset in the middle of a blank discards the pending value.
        anode_in = 4'b1110; repeat (10) tick("pre_reset");
        do_load(16'hABCD, 4'b1000, "load_abcd");
        anode_in = 4'b1101; repeat (4) tick("mid_blank");
        #2 reset = 1'b0;
        #1 check("async_reset", outs, RST_OUT);
        model_reset();
        repeat (2) tick("in_reset");
        reset = 1'b1;
        anode_in = 4'b1110;
        repeat (12) tick("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
